ex_mdu: RTL and testbench
=========================

# ex_mdu

Parametrised execute stage for the five-stage pipeline. It keeps single-cycle logic and shift results, generalised to `DATA_W`. It adds a multi-cycle multiply/divide unit that writes the HI/LO pair and holds the pipeline through `stallreq_o` until the result is ready. It sits between the ID/EX and EX/MEM pipeline registers; stall control feeds the pipeline controller.

## Interface
Parameters:
- `DATA_W`, 32: operand, result and HI/LO width; must be at least 8 and a power of two.
- `REG_ADDR_W`, 5: destination register address width.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `aluop_i` in 8: operation code (shared package).
- `alusel_i` in 3: result class (shared package).
- `reg1_i` in DATA_W: operand 1; shift amount for shifts; dividend / multiplicand.
- `reg2_i` in DATA_W: operand 2; shifted value; divisor / multiplier.
- `wd_i` in REG_ADDR_W: destination register.
- `wreg_i` in 1: GPR write enable.
- `flush_i` in 1: abort any in-flight multiply/divide.
- `wd_o` out REG_ADDR_W: forwarded `wd_i`.
- `wreg_o` out 1: forwarded `wreg_i`.
- `wdata_o` out DATA_W: GPR result.
- `whilo_o` out 1: HI/LO write strobe, 1 cycle.
- `hi_o`, `lo_o` out DATA_W: HI/LO write data.
- `stallreq_o` out 1: request to hold the pipeline.

## Operation
- Shift amount is `reg1_i[$clog2(DATA_W)-1:0]`.
- Logic ops: OR, AND, NOR, XOR. Shift ops: SLL, SRL, SRA; SRA is sign-filling.
- Unknown `aluop_i` gives a logic/shift result of 0.
- `alusel_i` selects the logic result, the shift result, or 0 for `wdata_o`. `wd_o`/`wreg_o` pass through unchanged.
- MD ops are MULT, MULTU, DIV and DIVU. They write only HI/LO; decode drives `wreg_i`=0 for them.
- FSM states are IDLE, MUL, DIV and DONE.
  - IDLE, on an MD op with `flush_i`=0: capture operands and signedness.
    - MULT/MULTU go to MUL.
    - DIV/DIVU with a nonzero divisor go to DIV; the iteration counter is cleared.
    - DIV/DIVU with a zero divisor go to DONE with HI=`reg1_i` and LO=all-ones.
  - MUL: register the full 2·DATA_W product of the sign- or zero-extended operands, then go to DONE.
  - DIV: restoring radix-2 on operand magnitudes, one quotient bit per cycle, DATA_W cycles; go to DONE when the counter reaches DATA_W-1.
  - DIV sign fix-up on entry to DONE: quotient is negated if the operand signs differ (signed only); remainder takes the dividend's sign.
  - DONE: `whilo_o`=1, `hi_o`=high/remainder, `lo_o`=low/quotient; next state is IDLE.
- `stallreq_o` = (IDLE and MD op and not `flush_i`) or MUL or DIV. It is combinational and deasserted in DONE.
- The pipeline holds the inputs stable while stalled. In DONE the same MD op is still presented, and the FSM must not restart on it.
- `flush_i` in any state: next state is IDLE. `stallreq_o` and `whilo_o` are forced to 0 in the same cycle, and partial results are discarded.
- `rst` at any time, including mid-operation: state goes to IDLE immediately and partial results are cleared.

## Timing
- Reset values: all outputs 0, including `stallreq_o`, `whilo_o`, `hi_o`, `lo_o` and `wdata_o`.
- Logic and shift ops: 0-cycle latency (combinational), no stall.
- MULT/MULTU: 3 cycles occupied (IDLE, MUL, DONE), of which 2 are stalled.
- DIV/DIVU: DATA_W+2 cycles occupied, DATA_W+1 stalled.
- Divide by zero: 2 cycles occupied, 1 stalled.
- `hi_o`/`lo_o` are valid only while `whilo_o`=1; otherwise they are 0.
- Back-to-back MD ops: the second one starts in the IDLE cycle after DONE.

## Configuration
- `EX_MDU_DIV_EN` defined: divider datapath and the DIV state are built.
- `EX_MDU_DIV_EN` undefined: DIV/DIVU behave as NOPs, with no stall, `whilo_o`=0 and `wdata_o`=0. The FSM contains only IDLE, MUL and DONE.

## Structure
- Shared package holds:
  - `aluop`/`alusel` codes (existing plus `EXE_MULT_OP`, `EXE_MULTU_OP`, `EXE_DIV_OP`, `EXE_DIVU_OP`);
  - FSM state encodings;
  - `RstEnable`, `ZeroWord`.
- Sub-module `ex_div`: iterative signed/unsigned divider with start/abort/done. It is instantiated only under `EX_MDU_DIV_EN`.

## Test plan
All scenarios use DATA_W=32.
- Logic: OR 0x0000_FF00 with 0x00F0_00F0 -> `wdata_o`=0x00F0_FFF0 in the same cycle, `stallreq_o`=0.
- SRA: `reg2_i`=0x8000_0000, `reg1_i`=4 -> 0xF800_0000. SRL on the same inputs -> 0x0800_0000.
- Multiply:
  - MULT -3×5 -> 2 stall cycles, then `whilo_o`=1 with HI=0xFFFF_FFFF, LO=0xFFFF_FFF1.
  - MULTU 0xFFFF_FFFF×2 -> HI=1, LO=0xFFFF_FFFE.
- Divide:
  - DIV -7/2 -> 33 stall cycles, then LO=0xFFFF_FFFD, HI=0xFFFF_FFFF.
  - DIVU 100/7 -> LO=14, HI=2.
- Divide by zero: DIV with `reg1_i`=0x1234, `reg2_i`=0 -> 1 stall cycle, then HI=0x1234, LO=0xFFFF_FFFF.
- Abort and recovery:
  - `flush_i` on DIV iteration 10 -> `stallreq_o` drops the same cycle and no `whilo_o`. A following DIVU 9/3 then completes with LO=3, HI=0.
  - `rst` pulsed mid-MUL -> all outputs 0 immediately.

Source files
------------

// File: rtl/ex_mdu_pkg.sv
// Shared opcodes, result classes and multiply/divide FSM encodings for ex_mdu.
// EX_MDU_DIV_EN adds the DIV state; without it the FSM has only IDLE, MUL and DONE.
package ex_mdu_pkg;

  localparam logic        RstEnable = 1'b1;
  localparam logic [31:0] ZeroWord  = 32'h0000_0000;

  localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

  localparam logic [2:0] EXE_RES_NOP   = 3'b000;
  localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

`ifdef EX_MDU_DIV_EN
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;
`else
  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DONE = 2'd3
  } md_state_e;
`endif

endpackage

// File: rtl/ex_div.sv
// Iterative restoring radix-2 divider: one quotient bit per cycle on operand magnitudes,
// signs restored on the final iteration (quotient by operand signs, remainder by dividend).
module ex_div
  import ex_mdu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              signed_op,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              done,
  output logic [DATA_W-1:0] quot,
  output logic [DATA_W-1:0] rem
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  logic              busy, neg_q, neg_r;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] q, r, d, q_nxt, r_nxt;
  logic [DATA_W:0]   r_sh;
  logic [DATA_W+1:0] diff;
  logic              unused_msbs;

  // The shifted partial remainder needs one extra bit; the borrow of the trial subtraction picks the quotient bit.
  always_comb begin
    r_sh = {r, q[DATA_W-1]};
    diff = {1'b0, r_sh} - {2'b00, d};
    if (diff[DATA_W+1]) begin
      r_nxt = r_sh[DATA_W-1:0];
      q_nxt = {q[DATA_W-2:0], 1'b0};
    end else begin
      r_nxt = diff[DATA_W-1:0];
      q_nxt = {q[DATA_W-2:0], 1'b1};
    end
  end

  assign unused_msbs = r_sh[DATA_W] ^ diff[DATA_W];
  assign done = busy && (cnt == LAST);
  assign quot = neg_q ? -q_nxt : q_nxt;
  assign rem  = neg_r ? -r_nxt : r_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      busy  <= 1'b0;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      d     <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (abort) begin
      busy <= 1'b0;
      q    <= '0;
      r    <= '0;
    end else if (start) begin
      busy  <= 1'b1;
      cnt   <= '0;
      q     <= (signed_op && dividend[DATA_W-1]) ? -dividend : dividend;
      r     <= '0;
      d     <= (signed_op && divisor[DATA_W-1]) ? -divisor : divisor;
      neg_q <= signed_op && (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
      neg_r <= signed_op && dividend[DATA_W-1];
    end else if (busy) begin
      q   <= q_nxt;
      r   <= r_nxt;
      cnt <= cnt + CNT_W'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/ex_mdu.sv
// Execute stage: combinational logic/shift results plus a multi-cycle HI/LO multiply/divide unit
// that stalls the pipeline until done. Define EX_MDU_DIV_EN to build the divider.
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            aluop_i,
  input  logic [2:0]            alusel_i,
  input  logic [DATA_W-1:0]     reg1_i,
  input  logic [DATA_W-1:0]     reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic                  flush_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic                  whilo_o,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o,
  output logic                  stallreq_o
);

  localparam int SH_W = $clog2(DATA_W);

  md_state_e           state, state_nxt;
  logic [DATA_W-1:0]   logic_res, shift_res, op_a, op_b, hi_q, lo_q;
  logic [SH_W-1:0]     sh_amt;
  logic [2*DATA_W-1:0] ext_a, ext_b;
  logic                op_signed, is_mul, md_op, busy;

  assign sh_amt = reg1_i[SH_W-1:0];
  assign is_mul = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MULTU_OP);

`ifdef EX_MDU_DIV_EN
  logic              is_div, div_start, div_done;
  logic [DATA_W-1:0] div_quot, div_rem;

  assign is_div = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
  assign md_op  = is_mul || is_div;
  assign busy   = (state == MD_MUL) || (state == MD_DIV);

  ex_div #(.DATA_W(DATA_W)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .abort     (flush_i),
    .signed_op (aluop_i == EXE_DIV_OP),
    .dividend  (reg1_i),
    .divisor   (reg2_i),
    .done      (div_done),
    .quot      (div_quot),
    .rem       (div_rem)
  );
`else
  assign md_op = is_mul;
  assign busy  = (state == MD_MUL);
`endif

  always_comb begin
    logic_res = '0;
    case (aluop_i)
      EXE_OR_OP:  logic_res = reg1_i | reg2_i;
      EXE_AND_OP: logic_res = reg1_i & reg2_i;
      EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
      EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
      default:    logic_res = '0;
    endcase
  end

  always_comb begin
    shift_res = '0;
    case (aluop_i)
      EXE_SLL_OP: shift_res = reg2_i << sh_amt;
      EXE_SRL_OP: shift_res = reg2_i >> sh_amt;
      EXE_SRA_OP: shift_res = DATA_W'($signed(reg2_i) >>> sh_amt);
      default:    shift_res = '0;
    endcase
  end

  // Outputs are held at zero while reset is asserted, even though wd/wreg are otherwise pass-through.
  always_comb begin
    wdata_o = '0;
    wd_o    = '0;
    wreg_o  = 1'b0;
    if (rst != RstEnable) begin
      wd_o   = wd_i;
      wreg_o = wreg_i;
      case (alusel_i)
        EXE_RES_LOGIC: wdata_o = logic_res;
        EXE_RES_SHIFT: wdata_o = shift_res;
        default:       wdata_o = '0;
      endcase
    end
  end

  // DONE always returns to IDLE, so the MD op still presented during DONE cannot restart the unit.
  always_comb begin
    state_nxt = state;
`ifdef EX_MDU_DIV_EN
    div_start = 1'b0;
`endif
    case (state)
      MD_IDLE: begin
        if (is_mul) state_nxt = MD_MUL;
`ifdef EX_MDU_DIV_EN
        else if (is_div) begin
          if (reg2_i == '0) state_nxt = MD_DONE;
          else begin
            state_nxt = MD_DIV;
            div_start = 1'b1;
          end
        end
      end
      MD_DIV: begin
        if (div_done) state_nxt = MD_DONE;
`endif
      end
      MD_MUL:  state_nxt = MD_DONE;
      MD_DONE: state_nxt = MD_IDLE;
      default: state_nxt = MD_IDLE;
    endcase
    if (flush_i) begin
      state_nxt = MD_IDLE;
`ifdef EX_MDU_DIV_EN
      div_start = 1'b0;
`endif
    end
  end

  assign stallreq_o = (rst != RstEnable) && !flush_i && (((state == MD_IDLE) && md_op) || busy);
  assign whilo_o    = (state == MD_DONE) && !flush_i;
  assign hi_o       = whilo_o ? hi_q : '0;
  assign lo_o       = whilo_o ? lo_q : '0;

  assign ext_a = op_signed ? {{DATA_W{op_a[DATA_W-1]}}, op_a} : {{DATA_W{1'b0}}, op_a};
  assign ext_b = op_signed ? {{DATA_W{op_b[DATA_W-1]}}, op_b} : {{DATA_W{1'b0}}, op_b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RstEnable) begin
      state     <= MD_IDLE;
      op_a      <= '0;
      op_b      <= '0;
      op_signed <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state <= state_nxt;
      if (flush_i) begin
        hi_q <= '0;
        lo_q <= '0;
      end else begin
        case (state)
          MD_IDLE: begin
            if (is_mul) begin
              op_a      <= reg1_i;
              op_b      <= reg2_i;
              op_signed <= (aluop_i == EXE_MULT_OP);
            end
`ifdef EX_MDU_DIV_EN
            else if (is_div && (reg2_i == '0)) begin
              hi_q <= reg1_i;
              lo_q <= '1;
            end
          end
          MD_DIV: begin
            if (div_done) begin
              hi_q <= div_rem;
              lo_q <= div_quot;
            end
`endif
          end
          MD_MUL:  {hi_q, lo_q} <= ext_a * ext_b;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ex_mdu.sv
// Scoreboard bench for ex_mdu (DATA_W=32): directed vectors, HI/LO writes checked by a monitor.
// DIV expectations follow EX_MDU_DIV_EN (real divide when defined, NOP otherwise).
module tb_ex_mdu;
  import ex_mdu_pkg::*;

  logic        clk, rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i, reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i, flush_i;
  logic [4:0]  wd_o;
  logic        wreg_o, whilo_o, stallreq_o;
  logic [31:0] wdata_o, hi_o, lo_o;

  int vectors = 0;
  int miscompares = 0;
  logic [63:0] exp_q[$];
  string       name_q[$];

  typedef struct {
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
  } lvec_t;

  lvec_t lv[12] = '{
    '{EXE_OR_OP,  EXE_RES_LOGIC, 32'h0000_FF00, 32'h00F0_00F0, 32'h00F0_FFF0},
    '{EXE_AND_OP, EXE_RES_LOGIC, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'h00F0_1234},
    '{EXE_NOR_OP, EXE_RES_LOGIC, 32'h0000_FF00, 32'h00F0_00F0, 32'hFF0F_000F},
    '{EXE_XOR_OP, EXE_RES_LOGIC, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555},
    '{EXE_SRA_OP, EXE_RES_SHIFT, 32'd4,         32'h8000_0000, 32'hF800_0000},
    '{EXE_SRL_OP, EXE_RES_SHIFT, 32'd4,         32'h8000_0000, 32'h0800_0000},
    '{EXE_SLL_OP, EXE_RES_SHIFT, 32'h24,        32'h0000_0081, 32'h0000_0810},
    '{EXE_SRA_OP, EXE_RES_SHIFT, 32'd16,        32'h7FFF_0000, 32'h0000_7FFF},
    '{8'hFF,      EXE_RES_LOGIC, 32'h1234,      32'h5678,      32'h0000_0000},
    '{EXE_OR_OP,  EXE_RES_NOP,   32'hFFFF,      32'h1,         32'h0000_0000},
    '{EXE_SLL_OP, EXE_RES_SHIFT, 32'd0,         32'hDEAD_BEEF, 32'hDEAD_BEEF},
    '{EXE_SRA_OP, EXE_RES_SHIFT, 32'd31,        32'h8000_0000, 32'hFFFF_FFFF}
  };

  ex_mdu #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .aluop_i    (aluop_i),
    .alusel_i   (alusel_i),
    .reg1_i     (reg1_i),
    .reg2_i     (reg2_i),
    .wd_i       (wd_i),
    .wreg_i     (wreg_i),
    .flush_i    (flush_i),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .whilo_o    (whilo_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .stallreq_o (stallreq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] wd, input logic wreg);
    aluop_i  = op;
    alusel_i = sel;
    reg1_i   = a;
    reg2_i   = b;
    wd_i     = wd;
    wreg_i   = wreg;
  endtask

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Issue one MD op, push its HI/LO expectation (if any) and count the stall cycles.
  task automatic runMd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int exp_stall, input logic exp_wr, input logic [31:0] ehi,
                       input logic [31:0] elo, input string nm);
    int stalls;
    stalls = 0;
    if (exp_wr) begin
      exp_q.push_back({ehi, elo});
      name_q.push_back(nm);
    end
    @(posedge clk);
    #1 applyStimulus(op, EXE_RES_NOP, a, b, 5'd0, 1'b0);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stallreq_o) break;
      stalls++;
    end
    checkOutput({nm, " stall cycles"}, 64'(stalls), 64'(exp_stall));
  endtask

  initial begin : monitor
    logic [63:0] exp;
    string nm;
    @(negedge rst);
    forever begin
      @(negedge clk);
      vectors++;
      if (whilo_o) begin
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("[TB] FAIL unexpected whilo: got hi=%h lo=%h, required no HI/LO write", hi_o, lo_o);
        end else begin
          exp = exp_q.pop_front();
          nm  = name_q.pop_front();
          if ({hi_o, lo_o} !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s hilo: got hi=%h lo=%h, required hi=%h lo=%h",
                     nm, hi_o, lo_o, exp[63:32], exp[31:0]);
          end
        end
      end else if ((hi_o !== 32'h0) || (lo_o !== 32'h0)) begin
        miscompares++;
        $display("[TB] FAIL idle hilo: got hi=%h lo=%h, required 0 without whilo", hi_o, lo_o);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    rst = 1'b1;
    flush_i = 1'b0;
    applyStimulus(EXE_OR_OP, EXE_RES_LOGIC, 32'hFFFF, 32'h1, 5'd7, 1'b1);
    #3;
    checkOutput("reset wdata", 64'(wdata_o), 64'h0);
    checkOutput("reset wd", 64'(wd_o), 64'h0);
    checkOutput("reset wreg", 64'(wreg_o), 64'h0);
    applyStimulus(EXE_MULT_OP, EXE_RES_NOP, 32'h3, 32'h5, 5'd7, 1'b1);
    #1;
    checkOutput("reset stall", 64'(stallreq_o), 64'h0);
    checkOutput("reset whilo", 64'(whilo_o), 64'h0);
    checkOutput("reset hilo", {hi_o, lo_o}, 64'h0);
    applyStimulus(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (lv[i]) begin
      @(posedge clk);
      #1 applyStimulus(lv[i].op, lv[i].sel, lv[i].a, lv[i].b, 5'(i + 1), i[0]);
      @(negedge clk);
      checkOutput($sformatf("logic vec %0d wdata", i), 64'(wdata_o), 64'(lv[i].res));
      checkOutput($sformatf("logic vec %0d stall", i), 64'(stallreq_o), 64'h0);
      checkOutput($sformatf("logic vec %0d wd", i), 64'(wd_o), 64'(i + 1));
      checkOutput($sformatf("logic vec %0d wreg", i), 64'(wreg_o), 64'(i % 2));
    end

    runMd(EXE_MULT_OP,  32'hFFFF_FFFD, 32'd5, 2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult -3x5");
    runMd(EXE_MULTU_OP, 32'hFFFF_FFFF, 32'd2, 2, 1'b1, 32'h0000_0001, 32'hFFFF_FFFE, "multu max x2");
    runMd(EXE_MULT_OP,  32'h8000_0000, 32'h8000_0000, 2, 1'b1, 32'h4000_0000, 32'h0, "mult min x min");
`ifdef EX_MDU_DIV_EN
    runMd(EXE_DIV_OP,  32'hFFFF_FFF9, 32'd2, 33, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2");
    runMd(EXE_DIVU_OP, 32'd100, 32'd7, 33, 1'b1, 32'd2, 32'd14, "divu 100/7");
    runMd(EXE_DIV_OP,  32'd7, 32'hFFFF_FFFE, 33, 1'b1, 32'd1, 32'hFFFF_FFFD, "div 7/-2");
    runMd(EXE_DIV_OP,  32'h1234, 32'h0, 1, 1'b1, 32'h1234, 32'hFFFF_FFFF, "div by zero");

    // Flush on iteration 10 of a divide: stall must drop at once and no HI/LO write may follow.
    @(posedge clk);
    #1 applyStimulus(EXE_DIV_OP, EXE_RES_NOP, 32'd100, 32'd7, 5'd0, 1'b0);
    repeat (11) @(posedge clk);
    #1 checkOutput("div busy before flush", 64'(stallreq_o), 64'h1);
    flush_i = 1'b1;
    #1;
    checkOutput("flush stall", 64'(stallreq_o), 64'h0);
    checkOutput("flush whilo", 64'(whilo_o), 64'h0);
    @(posedge clk);
    #1 flush_i = 1'b0;
    applyStimulus(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    repeat (40) @(negedge clk);
    runMd(EXE_DIVU_OP, 32'd9, 32'd3, 33, 1'b1, 32'd0, 32'd3, "divu 9/3 after flush");
`else
    runMd(EXE_DIV_OP,  32'hFFFF_FFF9, 32'd2, 0, 1'b0, 32'h0, 32'h0, "div disabled");
    runMd(EXE_DIVU_OP, 32'd100, 32'd7, 0, 1'b0, 32'h0, 32'h0, "divu disabled");
`endif

    // Reset pulse while a multiply is in the MUL state.
    @(posedge clk);
    #1 applyStimulus(EXE_MULT_OP, EXE_RES_NOP, 32'd6, 32'd7, 5'd9, 1'b1);
    @(posedge clk);
    #1 checkOutput("mul busy before reset", 64'(stallreq_o), 64'h1);
    rst = 1'b1;
    #1;
    checkOutput("mid-mul reset stall", 64'(stallreq_o), 64'h0);
    checkOutput("mid-mul reset whilo", 64'(whilo_o), 64'h0);
    checkOutput("mid-mul reset hilo", {hi_o, lo_o}, 64'h0);
    checkOutput("mid-mul reset wd", 64'(wd_o), 64'h0);
    checkOutput("mid-mul reset wreg", 64'(wreg_o), 64'h0);
    @(negedge clk);
    #1 rst = 1'b0;
    applyStimulus(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    repeat (4) @(negedge clk);
    runMd(EXE_MULTU_OP, 32'h0001_0000, 32'h0001_0000, 2, 1'b1, 32'h1, 32'h0, "multu after reset");

    @(posedge clk);
    #1 applyStimulus(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("pending hilo writes", 64'(exp_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
